// File: rtl/class_score_accumulator.sv
// Ten-class linear score accumulator: streams feature-major (feature, class) beats,
// accumulates signed x*w products per class with saturation, then presents the scores.
module class_score_accumulator #(
    parameter int N_FEATURES = 784,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  image_number_0,
    output logic signed [ACC_W-1:0]  image_number_1,
    output logic signed [ACC_W-1:0]  image_number_2,
    output logic signed [ACC_W-1:0]  image_number_3,
    output logic signed [ACC_W-1:0]  image_number_4,
    output logic signed [ACC_W-1:0]  image_number_5,
    output logic signed [ACC_W-1:0]  image_number_6,
    output logic signed [ACC_W-1:0]  image_number_7,
    output logic signed [ACC_W-1:0]  image_number_8,
    output logic signed [ACC_W-1:0]  image_number_9
);

    localparam int N_CLASSES = 10;
    localparam int FEAT_W    = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
    localparam int PROD_W    = 2 * DATA_W;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [0:0]              state;
    logic [3:0]              class_cnt;
    logic [FEAT_W-1:0]       feat_cnt;
    logic signed [ACC_W-1:0] acc [N_CLASSES];

    logic                    accept;
    logic                    last_class;
    logic                    last_beat;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] acc_sel;
    logic signed [ACC_W-1:0] sat_val;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    assign last_class = (class_cnt == 4'(N_CLASSES - 1));
    assign last_beat  = last_class && (feat_cnt == FEAT_W'(N_FEATURES - 1));

    // Pick the accumulator addressed by the class counter without an
    // out-of-range array index for counter values 10..15.
    always_comb begin
        acc_sel = '0;
        for (int k = 0; k < N_CLASSES; k++) begin
            if (class_cnt == 4'(k)) begin
                acc_sel = acc[k];
            end
        end
    end

    assign prod     = x_in * w_in;
    assign prod_ext = (ACC_W+1)'(prod);
    assign acc_ext  = (ACC_W+1)'(acc_sel);
    assign sum      = acc_ext + prod_ext;

    // The two top bits of the widened sum disagree only on overflow; the MSB
    // then tells which rail to clamp to.
    always_comb begin
        sat_val = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat_val = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCUM;
            class_cnt <= '0;
            feat_cnt  <= '0;
            for (int k = 0; k < N_CLASSES; k++) begin
                acc[k] <= '0;
            end
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        for (int k = 0; k < N_CLASSES; k++) begin
                            if (class_cnt == 4'(k)) begin
                                acc[k] <= sat_val;
                            end
                        end
                        if (last_beat) begin
                            class_cnt <= '0;
                            feat_cnt  <= '0;
                            state     <= ST_DONE;
                        end else if (last_class) begin
                            class_cnt <= '0;
                            feat_cnt  <= feat_cnt + 1'b1;
                        end else begin
                            class_cnt <= class_cnt + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        for (int k = 0; k < N_CLASSES; k++) begin
                            acc[k] <= '0;
                        end
                        state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    assign image_number_0 = acc[0];
    assign image_number_1 = acc[1];
    assign image_number_2 = acc[2];
    assign image_number_3 = acc[3];
    assign image_number_4 = acc[4];
    assign image_number_5 = acc[5];
    assign image_number_6 = acc[6];
    assign image_number_7 = acc[7];
    assign image_number_8 = acc[8];
    assign image_number_9 = acc[9];

endmodule
